// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus of the memory access controller.
// The slave modport is the controller; the master modport is everything
// around it (requester plus memory read data).
interface mem_access_ctrl_if #(
  parameter int WordSize = 32
);
  logic                Req_Valid;
  logic                Req_Ready;
  logic                Req_Wr;
  logic                Req_Byte;
  logic [WordSize-1:0] Req_Addr;
  logic [WordSize-1:0] Req_Data;

  logic                Rsp_Valid;
  logic [WordSize-1:0] Rsp_Data;
  logic                Rsp_Err;

  logic [WordSize-1:0] Mem_Addr;
  logic                Mem_rd;
  logic                Mem_wr;
  logic [WordSize-1:0] Mem_DIN;
  logic [WordSize-1:0] Mem_DOUT;

  modport slave (
    input  Req_Valid, Req_Wr, Req_Byte, Req_Addr, Req_Data, Mem_DOUT,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
           Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );

  modport master (
    output Req_Valid, Req_Wr, Req_Byte, Req_Addr, Req_Data, Mem_DOUT,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
           Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns word/byte load/store requests into timed
// read/write strobes on a simple asynchronous-read data memory. Byte stores
// are done as read-modify-write of the containing word.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | Req_Ready=1, memory bus quiet, waiting for a request
// RD     | load: Mem_rd held RD_WAIT cycles, Mem_DOUT captured at the end
// RMW_RD | byte store: read containing word, merge lane at the end
// WR     | store: Mem_wr/Mem_DIN held WR_WAIT cycles
// RESP   | one-cycle Rsp_Valid pulse, memory bus quiet
module mem_access_ctrl #(
  parameter int WordSize = 32,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  localparam logic [7:0] RdLoad = 8'(RD_WAIT - 1);
  localparam logic [7:0] WrLoad = 8'(WR_WAIT - 1);

  state_t              state;
  logic [7:0]          cnt;
  logic [1:0]          lane;
  logic [7:0]          byte_data;
  logic                byte_q;

  logic                ready_q;
  logic                rsp_valid_q;
  logic [WordSize-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic [WordSize-1:0] mem_addr_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [WordSize-1:0] mem_din_q;

  logic [7:0]          lane_val;
  logic [WordSize-1:0] merged;

  // Lane extraction for byte loads and lane replacement for byte stores.
  always_comb begin
    lane_val = bus.Mem_DOUT[{lane, 3'b000} +: 8];
    merged   = bus.Mem_DOUT;
    merged[{lane, 3'b000} +: 8] = byte_data;
  end

  // Sequencer FSM; all bus outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      lane        <= '0;
      byte_data   <= '0;
      byte_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Req_Valid && ready_q) begin
            // Latch everything needed later so the requester may change its inputs.
            lane      <= bus.Req_Addr[1:0];
            byte_data <= bus.Req_Data[7:0];
            byte_q    <= bus.Req_Byte;
            ready_q   <= 1'b0;
            if (!bus.Req_Byte && (bus.Req_Addr[1:0] != 2'b00)) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else if (!bus.Req_Wr || bus.Req_Byte) begin
              state      <= bus.Req_Wr ? RMW_RD : RD;
              cnt        <= RdLoad;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {bus.Req_Addr[WordSize-1:2], 2'b00};
            end else begin
              state      <= WR;
              cnt        <= WrLoad;
              mem_wr_q   <= 1'b1;
              mem_addr_q <= {bus.Req_Addr[WordSize-1:2], 2'b00};
              mem_din_q  <= bus.Req_Data;
            end
          end
        end

        RD: begin
          if (cnt == 8'd0) begin
            state       <= RESP;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= byte_q ? WordSize'(lane_val) : bus.Mem_DOUT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RMW_RD: begin
          if (cnt == 8'd0) begin
            // Address is kept; the read strobe hands over directly to the write strobe.
            state     <= WR;
            cnt       <= WrLoad;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b1;
            mem_din_q <= merged;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        WR: begin
          if (cnt == 8'd0) begin
            state       <= RESP;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RESP: begin
          state       <= IDLE;
          cnt         <= '0;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_din_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Req_Ready = ready_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data  = rsp_data_q;
  assign bus.Rsp_Err   = rsp_err_q;
  assign bus.Mem_Addr  = mem_addr_q;
  assign bus.Mem_rd    = mem_rd_q;
  assign bus.Mem_wr    = mem_wr_q;
  assign bus.Mem_DIN   = mem_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests push expected
// responses; a negedge monitor pops and compares on every Rsp_Valid.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   viol;
  int   rd_cnt;
  int   wr_cnt;
  bit   prev_rsp;

  logic [31:0] mem [0:63];

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mem_access_ctrl_if #(.WordSize(32)) bus ();

  mem_access_ctrl #(
    .WordSize(32),
    .RD_WAIT (2),
    .WR_WAIT (1)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.Mem_DOUT = mem[bus.Mem_Addr[7:2]];

  // Memory model: initial contents, then writes on negedge while Mem_wr is high.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * 32'(i);
    mem[3] = 32'hDEAD_BEEF;
    mem[4] = 32'h0123_4567;
    mem[5] = 32'h89AB_CDEF;
    forever begin
      @(negedge clk);
      if (bus.Mem_wr) mem[bus.Mem_Addr[7:2]] = bus.Mem_DIN;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response monitor and bus protocol watcher.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt   = 0;
      wr_cnt   = 0;
      prev_rsp = 1'b0;
    end else begin
      if (bus.Mem_rd) rd_cnt++;
      if (bus.Mem_wr) wr_cnt++;
      if (bus.Mem_rd && bus.Mem_wr) viol++;
      if ((bus.Req_Ready || bus.Rsp_Valid) &&
          (bus.Mem_rd || bus.Mem_wr || bus.Mem_Addr != 0 || bus.Mem_DIN != 0)) viol++;
      if (bus.Rsp_Valid && prev_rsp) viol++;
      if (bus.Rsp_Valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(bus.Rsp_Valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, bus.Rsp_Data, e.data);
          check({e.name, "_err"}, 32'(bus.Rsp_Err), 32'(e.err));
          check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          check({e.name, "_rdcyc"}, 32'(rd_cnt), 32'(e.rd));
          check({e.name, "_wrcyc"}, 32'(wr_cnt), 32'(e.wr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      prev_rsp = bus.Rsp_Valid;
    end
  end

  // Present a request at a negedge, wait for acceptance, record the expectation.
  task automatic issue(input string name, input logic wr, input logic byt,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input int exp_rd, input int exp_wr,
                       input bit hold, output int acc);
    int n;
    bus.Req_Valid = 1'b1;
    bus.Req_Wr    = wr;
    bus.Req_Byte  = byt;
    bus.Req_Addr  = addr;
    bus.Req_Data  = data;
    n = 0;
    while (!bus.Req_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Req_Ready) begin
      check({name, "_accept_timeout"}, 32'(bus.Req_Ready), 32'd1);
      bus.Req_Valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    sb.push_back('{name, exp_data, exp_err, exp_lat, exp_rd, exp_wr, cyc});
    @(negedge clk);
    if (!hold) begin
      // Scramble inputs while busy; results must come from the latched request.
      bus.Req_Valid = 1'b0;
      bus.Req_Wr    = ~wr;
      bus.Req_Byte  = ~byt;
      bus.Req_Addr  = 32'hFFFF_FFFF;
      bus.Req_Data  = 32'h1234_5678;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.Req_Ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a0, a1, a2;
    cyc = 0; checks = 0; errors = 0; viol = 0;
    rd_cnt = 0; wr_cnt = 0; prev_rsp = 1'b0;
    rst_n = 1'b0;
    bus.Req_Valid = 1'b0;
    bus.Req_Wr    = 1'b0;
    bus.Req_Byte  = 1'b0;
    bus.Req_Addr  = '0;
    bus.Req_Data  = '0;

    repeat (2) @(negedge clk);
    check("rst_ready",     32'(bus.Req_Ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
    check("rst_rsp_err",   32'(bus.Rsp_Err),   32'd0);
    check("rst_rsp_data",  bus.Rsp_Data,       32'd0);
    check("rst_mem_ctl",   {30'd0, bus.Mem_rd, bus.Mem_wr}, 32'd0);
    check("rst_mem_addr",  bus.Mem_Addr,       32'd0);
    check("rst_mem_din",   bus.Mem_DIN,        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("ld_w_0c", 1'b0, 1'b0, 32'h0C, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 2, 0, 1'b0, a);
    drain();
    issue("ld_b_0e", 1'b0, 1'b1, 32'h0E, 32'h0, 32'h0000_00AD, 1'b0, 3, 2, 0, 1'b0, a);
    drain();
    issue("ld_b_0f", 1'b0, 1'b1, 32'h0F, 32'h0, 32'h0000_00DE, 1'b0, 3, 2, 0, 1'b0, a);
    drain();
    issue("ld_b_0c", 1'b0, 1'b1, 32'h0C, 32'h0, 32'h0000_00EF, 1'b0, 3, 2, 0, 1'b0, a);
    drain();

    issue("st_b_0d", 1'b1, 1'b1, 32'h0D, 32'h1234_5655, 32'h0, 1'b0, 4, 2, 1, 1'b0, a);
    drain();
    check("mem3_after_st_b", mem[3], 32'hDEAD_55EF);

    issue("ld_w_rb", 1'b0, 1'b0, 32'h0C, 32'h0, 32'hDEAD_55EF, 1'b0, 3, 2, 0, 1'b0, a);
    drain();
    repeat (3) @(negedge clk);
    check("rsp_data_hold", bus.Rsp_Data, 32'hDEAD_55EF);

    issue("st_mis_06", 1'b1, 1'b0, 32'h06, 32'hBAD0_BAD0, 32'h0, 1'b1, 1, 0, 0, 1'b0, a);
    drain();
    check("mem1_untouched", mem[1], 32'h0101_0101);
    repeat (3) @(negedge clk);
    check("rsp_err_hold", 32'(bus.Rsp_Err), 32'd1);

    issue("ld_mis_11", 1'b0, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0, a);
    drain();

    issue("st_w_10", 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0, 1, 1'b0, a);
    drain();
    check("mem4_after_st_w", mem[4], 32'hCAFE_F00D);

    issue("st_b_13", 1'b1, 1'b1, 32'h13, 32'h0000_00A5, 32'h0, 1'b0, 4, 2, 1, 1'b0, a);
    drain();
    check("mem4_after_st_b", mem[4], 32'hA5FE_F00D);

    issue("b2b0", 1'b0, 1'b0, 32'h14, 32'h0, 32'h89AB_CDEF, 1'b0, 3, 2, 0, 1'b1, a0);
    issue("b2b1", 1'b0, 1'b0, 32'h0C, 32'h0, 32'hDEAD_55EF, 1'b0, 3, 2, 0, 1'b1, a1);
    issue("b2b2", 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5FE_F00D, 1'b0, 3, 2, 0, 1'b0, a2);
    drain();
    check("b2b_gap01", 32'(a1 - a0), 32'd4);
    check("b2b_gap12", 32'(a2 - a1), 32'd4);

    // Reset in the middle of a word store: no write, no response.
    bus.Req_Valid = 1'b1;
    bus.Req_Wr    = 1'b1;
    bus.Req_Byte  = 1'b0;
    bus.Req_Addr  = 32'h18;
    bus.Req_Data  = 32'h1111_2222;
    @(posedge clk);
    #3;
    bus.Req_Valid = 1'b0;
    check("rst_mid_wr_before", 32'(bus.Mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_drop",  32'(bus.Mem_wr),    32'd0);
    check("rst_mid_ready",    32'(bus.Req_Ready), 32'd1);
    check("rst_mid_rspvalid", 32'(bus.Rsp_Valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_ready", 32'(bus.Req_Ready), 32'd1);
    check("mem6_untouched", mem[6], 32'h0606_0606);

    issue("ld_post_rst", 1'b0, 1'b0, 32'h14, 32'h0, 32'h89AB_CDEF, 1'b0, 3, 2, 0, 1'b0, a);
    drain();

    check("protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WordSize, default 32, meaning the data and address width.
REQ-002 SHALL have parameter RD_WAIT, default 2, meaning the number of cycles Mem_rd is held before Mem_DOUT is sampled (legal range 1..255).
REQ-003 SHALL have parameter WR_WAIT, default 1, meaning the number of cycles Mem_wr is held (legal range 1..255).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state SHALL change on the posedge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port Req_Valid, input, 1 bit: a request is present.
REQ-007 SHALL have port Req_Ready, output, 1 bit: the controller accepts a request this cycle.
REQ-008 SHALL have port Req_Wr, input, 1 bit: 1 means store, 0 means load.
REQ-009 SHALL have port Req_Byte, input, 1 bit: 1 means byte access, 0 means word access.
REQ-010 SHALL have port Req_Addr, input, WordSize bits: byte address.
REQ-011 SHALL have port Req_Data, input, WordSize bits: store data; byte stores use bits [7:0].
REQ-012 SHALL have port Rsp_Valid, output, 1 bit: a one-cycle completion pulse.
REQ-013 SHALL have port Rsp_Data, output, WordSize bits: load result, or 0 for stores and errors.
REQ-014 SHALL have port Rsp_Err, output, 1 bit: a misaligned access, qualified by Rsp_Valid.
REQ-015 SHALL have ports Mem_Addr (output, WordSize), Mem_rd (output, 1), Mem_wr (output, 1) and Mem_DIN (output, WordSize), which drive the data memory.
REQ-016 SHALL have port Mem_DOUT, input, WordSize bits: the asynchronous read data from the memory.

Function
REQ-017 SHALL implement states IDLE, RD, RMW_RD, WR and RESP, with registered outputs.
REQ-018 Req_Ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a posedge where Req_Valid and Req_Ready are both 1.
REQ-019 On accepting a word access with Req_Addr[1:0] != 0, the controller SHALL issue no memory access, go to RESP, and set Rsp_Err=1 and Rsp_Data=0.
REQ-020 On accepting a load (word, or any byte), the controller SHALL go to RD, hold Mem_rd=1 and Mem_Addr={Req_Addr[WordSize-1:2],2'b00} for RD_WAIT cycles, then capture Mem_DOUT and go to RESP.
REQ-021 A byte load SHALL return the lane selected by Addr[1:0] (lane 0 = bits [7:0], little-endian), zero-extended.
REQ-022 On accepting a word store, the controller SHALL go to WR and hold Mem_wr=1 and Mem_DIN=Req_Data for WR_WAIT cycles, so that at least one negedge CLK falls inside the window; it SHALL then go to RESP.
REQ-023 On accepting a byte store, the controller SHALL first go to RMW_RD and read the word as in RD.
REQ-024 The byte store SHALL then replace the lane selected by Addr[1:0] with Req_Data[7:0], go to WR with the merged word, and go to RESP.
REQ-025 In RESP, Rsp_Valid SHALL be 1 for exactly one cycle; the controller SHALL then return to IDLE, so back-to-back requests are spaced by at least one cycle of Req_Ready=1.
REQ-026 Rsp_Data and Rsp_Err SHALL hold their values until the next RESP.
REQ-027 Mem_rd and Mem_wr SHALL never be 1 in the same cycle.
REQ-028 In IDLE and RESP, Mem_rd, Mem_wr, Mem_Addr and Mem_DIN SHALL all be 0.
REQ-029 Latency from the accept edge to Rsp_Valid high SHALL be RD_WAIT+1 cycles for loads.
REQ-030 Latency SHALL be WR_WAIT+1 cycles for word stores.
REQ-031 Latency SHALL be RD_WAIT+WR_WAIT+1 cycles for byte stores.
REQ-032 Latency SHALL be 1 cycle for misaligned errors.
REQ-033 Request inputs SHALL be latched at accept, so that changes to them while the controller is busy are ignored.
REQ-034 The wait counter SHALL be 8 bits wide, SHALL load with WAIT-1 on state entry, and SHALL leave the state when it reaches 0.

Reset
REQ-035 While RST_N=0, the controller SHALL be in IDLE, the counter SHALL be 0, and Req_Ready SHALL be 1.
REQ-036 While RST_N=0, Rsp_Valid, Rsp_Err, Rsp_Data, Mem_rd, Mem_wr, Mem_Addr and Mem_DIN SHALL all be 0.
REQ-037 Reset asserted mid-operation SHALL drop Mem_wr immediately (asynchronously), SHALL abandon the access without a response, and SHALL leave no pending state after release.

Verification
REQ-038 The bench SHALL cover a word load: memory word 3 = 0xDEADBEEF, load Addr 0x0C -> Mem_rd high for 2 cycles, then Rsp_Valid pulse with Rsp_Data=0xDEADBEEF at cycle 3.
REQ-039 The bench SHALL cover a byte load: same memory, load byte Addr 0x0E -> Rsp_Data=0x000000AD.
REQ-040 The bench SHALL cover a byte store: word 3 = 0xDEADBEEF, store byte 0x55 at Addr 0x0D -> memory word 3 = 0xDEAD55EF, Rsp_Valid at cycle 4, Mem_rd and Mem_wr never overlapping.
REQ-041 The bench SHALL cover a misaligned access: word store at Addr 0x06 -> no Mem_wr, Rsp_Err=1 and Rsp_Data=0 at cycle 1.
REQ-042 The bench SHALL cover reset mid-store: RST_N low during WR -> Mem_wr=0 at once, no Rsp_Valid, Req_Ready=1 after release.
REQ-043 The bench SHALL cover back-to-back traffic: Req_Valid held high for 3 word loads -> 3 responses, each accept separated by the documented latency plus 1 cycle.
